// File: rtl/snitch_ro_cache_pkg.sv
// Shared types and constants for the read-only cache request adapter:
// order-FIFO entry, lane index sizing and default AXI channel structs.
package snitch_ro_cache_pkg;

  localparam int unsigned AxiAddrWidthDef = 32;
  localparam int unsigned AxiDataWidthDef = 64;
  localparam int unsigned AxiIdWidthDef   = 2;
  localparam int unsigned AxiUserWidthDef = 1;

  // Widest lane index supported (1024-bit AXI over 32-bit core data).
  localparam int unsigned LaneMaxW = 5;

  localparam logic [3:0] CacheAttr = 4'b0010;
  localparam logic [1:0] BurstIncr = 2'b01;

  typedef struct packed {
    logic                write;
    logic [LaneMaxW-1:0] lane;
  } order_entry_t;

  function automatic int unsigned lane_idx_w(input int unsigned axi_dw, input int unsigned dw);
    return (axi_dw > dw) ? $clog2(axi_dw / dw) : 1;
  endfunction

  typedef struct packed {
    logic [AxiIdWidthDef-1:0]   id;
    logic [AxiAddrWidthDef-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic                       lock;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
    logic [3:0]                 qos;
    logic [3:0]                 region;
    logic [AxiUserWidthDef-1:0] user;
  } axi_ax_t;

  typedef struct packed {
    logic [AxiDataWidthDef-1:0]   data;
    logic [AxiDataWidthDef/8-1:0] strb;
    logic                         last;
    logic [AxiUserWidthDef-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdWidthDef-1:0]   id;
    logic [1:0]                 resp;
    logic [AxiUserWidthDef-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdWidthDef-1:0]   id;
    logic [AxiDataWidthDef-1:0] data;
    logic [1:0]                 resp;
    logic                       last;
    logic [AxiUserWidthDef-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

endpackage

// File: rtl/snitch_ro_cache_req_wr_issue.sv
// Store issue tracking: drives AW/W valid until each channel has handshaken
// and signals acceptance once both are complete (including this cycle).
module snitch_ro_cache_req_wr_issue
  import snitch_ro_cache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_store_req,
  input  logic i_aw_ready,
  input  logic i_w_ready,
  output logic o_aw_valid_c,
  output logic o_w_valid_c,
  output logic o_accept_c
);

  logic r_aw_done;
  logic r_w_done;
  logic w_aw_hs;
  logic w_w_hs;

  assign o_aw_valid_c = i_store_req && !r_aw_done;
  assign o_w_valid_c  = i_store_req && !r_w_done;
  assign w_aw_hs      = o_aw_valid_c && i_aw_ready;
  assign w_w_hs       = o_w_valid_c && i_w_ready;
  assign o_accept_c   = i_store_req && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (o_accept_c) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/snitch_ro_cache_req_adapter.sv
// Core valid/ready memory port to single-beat AXI4: loads on AR/R, stores on
// AW/W/B, responses returned in issue order through an order FIFO.
module snitch_ro_cache_req_adapter
  import snitch_ro_cache_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 2,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MaxTrans     = 4,
  parameter int unsigned FixedId      = 0,
  parameter type         axi_req_t    = snitch_ro_cache_pkg::axi_req_t,
  parameter type         axi_rsp_t    = snitch_ro_cache_pkg::axi_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic                    req_write_i,
  input  logic [DataWidth-1:0]    req_wdata_i,
  input  logic [DataWidth/8-1:0]  req_strb_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output logic [DataWidth-1:0]    rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output axi_req_t                axi_mst_req_o,
  input  axi_rsp_t                axi_mst_rsp_i
);

  localparam int unsigned NumLanes = AxiDataWidth / DataWidth;
  localparam int unsigned LaneW    = lane_idx_w(AxiDataWidth, DataWidth);
  localparam int unsigned StrbW    = DataWidth / 8;
  localparam int unsigned AxiStrbW = AxiDataWidth / 8;
  localparam int unsigned DataOffW = $clog2(StrbW);
  localparam int unsigned PtrW     = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW     = $clog2(MaxTrans + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [LaneW-1:0]    w_lane;
  logic                w_full;
  logic                w_issue_ok;
  logic                w_load_req;
  logic                w_store_req;
  logic                w_ar_hs;
  logic                w_aw_valid;
  logic                w_w_valid;
  logic                w_store_accept;
  logic                w_push;
  logic                w_pop;
  order_entry_t        w_push_entry;
  order_entry_t        w_head;
  logic                w_head_valid;
  logic                w_rsp_free;
  logic                w_r_ready;
  logic                w_b_ready;
  logic                w_r_hs;
  logic                w_b_hs;
  logic [DataWidth-1:0] w_rdata_sel;
  logic [AxiStrbW-1:0] w_strb;

  order_entry_t        r_fifo_q [MaxTrans];
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [CntW-1:0]     r_cnt;
  logic                r_rsp_valid;
  logic [DataWidth-1:0] r_rsp_rdata;
  logic                r_rsp_error;

  // Lane of the core word within the AXI beat.
  assign w_lane = (NumLanes > 1) ? LaneW'(req_addr_i >> DataOffW) : '0;
  assign w_strb = AxiStrbW'(req_strb_i) << (32'(w_lane) * StrbW);

  // Issue is blocked while full, even if a pop happens this cycle.
  assign w_full      = (r_cnt == CntW'(MaxTrans));
  assign w_issue_ok  = req_valid_i && !w_full;
  assign w_load_req  = w_issue_ok && !req_write_i;
  assign w_store_req = w_issue_ok && req_write_i;
  assign w_ar_hs     = w_load_req && axi_mst_rsp_i.ar_ready;

  snitch_ro_cache_req_wr_issue u_wr_issue (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .i_store_req  (w_store_req),
    .i_aw_ready   (axi_mst_rsp_i.aw_ready),
    .i_w_ready    (axi_mst_rsp_i.w_ready),
    .o_aw_valid_c (w_aw_valid),
    .o_w_valid_c  (w_w_valid),
    .o_accept_c   (w_store_accept)
  );

  assign req_ready_o  = w_ar_hs || w_store_accept;
  assign w_push       = w_ar_hs || w_store_accept;
  assign w_push_entry = '{write: req_write_i, lane: LaneMaxW'(w_lane)};

  // The head entry decides which response channel may be accepted.
  assign w_head       = r_fifo_q[r_rptr];
  assign w_head_valid = (r_cnt != '0);
  assign w_rsp_free   = !r_rsp_valid || rsp_ready_i;
  assign w_r_ready    = w_head_valid && !w_head.write && w_rsp_free;
  assign w_b_ready    = w_head_valid && w_head.write && w_rsp_free;
  assign w_r_hs       = w_r_ready && axi_mst_rsp_i.r_valid;
  assign w_b_hs       = w_b_ready && axi_mst_rsp_i.b_valid;
  assign w_pop        = w_r_hs || w_b_hs;
  assign w_rdata_sel  = DataWidth'(axi_mst_rsp_i.r.data >> (32'(w_head.lane) * DataWidth));

  always_comb begin
    axi_mst_req_o          = '0;
    axi_mst_req_o.ar.id    = AxiIdWidth'(FixedId);
    axi_mst_req_o.ar.addr  = req_addr_i;
    axi_mst_req_o.ar.size  = 3'(req_size_i);
    axi_mst_req_o.ar.burst = BurstIncr;
    axi_mst_req_o.ar.cache = CacheAttr;
    axi_mst_req_o.ar_valid = w_load_req;
    axi_mst_req_o.aw.id    = AxiIdWidth'(FixedId);
    axi_mst_req_o.aw.addr  = req_addr_i;
    axi_mst_req_o.aw.size  = 3'(req_size_i);
    axi_mst_req_o.aw.burst = BurstIncr;
    axi_mst_req_o.aw.cache = CacheAttr;
    axi_mst_req_o.aw_valid = w_aw_valid;
    axi_mst_req_o.w.data   = {NumLanes{req_wdata_i}};
    axi_mst_req_o.w.strb   = w_strb;
    axi_mst_req_o.w.last   = 1'b1;
    axi_mst_req_o.w_valid  = w_w_valid;
    axi_mst_req_o.r_ready  = w_r_ready;
    axi_mst_req_o.b_ready  = w_b_ready;
  end

  // Order FIFO (registered head, no fall-through).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxTrans; i++) r_fifo_q[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_q[r_wptr] <= w_push_entry;
        r_wptr           <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_r_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= w_rdata_sel;
      r_rsp_error <= axi_mst_rsp_i.r.resp[1];
    end else if (w_b_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_error <= axi_mst_rsp_i.b.resp[1];
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_error_o = r_rsp_error;

  logic w_unused;
  assign w_unused = ^{axi_mst_rsp_i.r.id, axi_mst_rsp_i.r.last, axi_mst_rsp_i.r.user,
                      axi_mst_rsp_i.r.resp[0], axi_mst_rsp_i.b.id, axi_mst_rsp_i.b.user,
                      axi_mst_rsp_i.b.resp[0]};

endmodule

// File: tb/tb_snitch_ro_cache_req_adapter.sv
// Directed bench for snitch_ro_cache_req_adapter: issue-path vector table
// plus hand-written multi-cycle sequences with a bench-driven AXI slave.
module tb_snitch_ro_cache_req_adapter;
  import snitch_ro_cache_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic [1:0]  req_size_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  axi_req_t    axi_req;
  axi_rsp_t    axi_rsp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  snitch_ro_cache_req_adapter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_addr_i    (req_addr_i),
    .req_write_i   (req_write_i),
    .req_wdata_i   (req_wdata_i),
    .req_strb_i    (req_strb_i),
    .req_size_i    (req_size_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_error_o   (rsp_error_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .axi_mst_req_o (axi_req),
    .axi_mst_rsp_i (axi_rsp)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
    logic        ar_rdy, aw_rdy, w_rdy;
    logic        e_ar_v, e_aw_v, e_w_v, e_rdy;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] sz, logic arr, logic awr, logic wrr,
                              logic ear, logic eaw, logic ew, logic erd,
                              logic [7:0] es, logic [63:0] ed);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = d; v.strb = s; v.size = sz;
    v.ar_rdy = arr; v.aw_rdy = awr; v.w_rdy = wrr;
    v.e_ar_v = ear; v.e_aw_v = eaw; v.e_w_v = ew; v.e_rdy = erd;
    v.e_strb = es; v.e_wdata = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] sz);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a;
    req_wdata_i = d; req_strb_i = s; req_size_i = sz;
  endtask

  int pulses;
  logic [31:0] exp_c [5];

  initial begin
    vecs[0] = mk(0, 32'h1004, 32'h0, 4'h0, 2, 1, 0, 0, 1, 0, 0, 1, 8'h00, 64'h0);
    vecs[1] = mk(0, 32'h1000, 32'h0, 4'h0, 1, 0, 1, 1, 1, 0, 0, 0, 8'h00, 64'h0);
    vecs[2] = mk(1, 32'h2004, 32'h1234_5678, 4'hF, 2, 0, 1, 1, 0, 1, 1, 1, 8'hF0, 64'h1234_5678_1234_5678);
    vecs[3] = mk(1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 1, 0, 1, 0, 0, 1, 1, 0, 8'h03, 64'hDEAD_BEEF_DEAD_BEEF);
    vecs[4] = mk(1, 32'h200C, 32'hDEAD_BEEF, 4'hC, 1, 0, 0, 1, 0, 1, 1, 0, 8'hC0, 64'hDEAD_BEEF_DEAD_BEEF);
    vecs[5] = mk(1, 32'h3008, 32'h0000_00FF, 4'h1, 0, 1, 0, 0, 0, 1, 1, 0, 8'h01, 64'h0000_00FF_0000_00FF);
    exp_c[0] = 32'hA000_0000; exp_c[1] = 32'hB000_0001; exp_c[2] = 32'hA000_0002;
    exp_c[3] = 32'hB000_0003; exp_c[4] = 32'hA000_0004;

    rst_ni = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_strb_i = '0; req_size_i = '0; rsp_ready_i = 1'b1; axi_rsp = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_error", rsp_error_o, 0);
    chk("rst_axi_valids", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}, 0);
    chk("rst_axi_readys", {axi_req.r_ready, axi_req.b_ready}, 0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Issue-path vectors, withdrawn before the clock edge so no state changes
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      drive_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].size);
      axi_rsp.ar_ready = vecs[i].ar_rdy;
      axi_rsp.aw_ready = vecs[i].aw_rdy;
      axi_rsp.w_ready  = vecs[i].w_rdy;
      #1;
      chk($sformatf("vec%0d_ar_valid", i), axi_req.ar_valid, vecs[i].e_ar_v);
      chk($sformatf("vec%0d_aw_valid", i), axi_req.aw_valid, vecs[i].e_aw_v);
      chk($sformatf("vec%0d_w_valid", i), axi_req.w_valid, vecs[i].e_w_v);
      chk($sformatf("vec%0d_req_ready", i), req_ready_o, vecs[i].e_rdy);
      if (vecs[i].write) begin
        chk($sformatf("vec%0d_w_strb", i), axi_req.w.strb, vecs[i].e_strb);
        chk($sformatf("vec%0d_w_data", i), axi_req.w.data, vecs[i].e_wdata);
        chk($sformatf("vec%0d_w_last", i), axi_req.w.last, 1);
        chk($sformatf("vec%0d_aw_addr", i), axi_req.aw.addr, vecs[i].addr);
        chk($sformatf("vec%0d_aw_attr", i),
            {axi_req.aw.len, axi_req.aw.burst, axi_req.aw.cache, axi_req.aw.size},
            {8'd0, 2'b01, 4'b0010, 1'b0, vecs[i].size});
      end else begin
        chk($sformatf("vec%0d_ar_addr", i), axi_req.ar.addr, vecs[i].addr);
        chk($sformatf("vec%0d_ar_attr", i),
            {axi_req.ar.len, axi_req.ar.burst, axi_req.ar.cache, axi_req.ar.size},
            {8'd0, 2'b01, 4'b0010, 1'b0, vecs[i].size});
      end
      req_valid_i = 1'b0;
      axi_rsp = '0;
    end

    // A: single load, upper lane
    @(negedge clk_i);
    drive_req(0, 32'h1004, 0, 0, 2); axi_rsp.ar_ready = 1'b1;
    #1;
    chk("A_ar_valid", axi_req.ar_valid, 1);
    chk("A_ar_addr", axi_req.ar.addr, 32'h1004);
    chk("A_ar_len", axi_req.ar.len, 0);
    chk("A_req_ready", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0; axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'hAAAA_BBBB_CCCC_DDDD; axi_rsp.r.resp = 2'b00;
    #1;
    chk("A_r_ready", axi_req.r_ready, 1);
    chk("A_rsp_valid_before", rsp_valid_o, 0);
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("A_rsp_valid", rsp_valid_o, 1);
    chk("A_rsp_rdata", rsp_rdata_o, 32'hAAAA_BBBB);
    chk("A_rsp_error", rsp_error_o, 0);
    @(negedge clk_i);
    #1 chk("A_rsp_consumed", rsp_valid_o, 0);

    // B: store, W ready three cycles before AW
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      drive_req(1, 32'h2004, 32'h1234_5678, 4'hF, 2);
      axi_rsp.w_ready  = (c == 0);
      axi_rsp.aw_ready = (c == 3);
      #1;
      chk($sformatf("B_aw_valid_c%0d", c), axi_req.aw_valid, 1);
      chk($sformatf("B_w_valid_c%0d", c), axi_req.w_valid, (c == 0));
      if (req_ready_o) pulses++;
    end
    chk("B_w_strb", axi_req.w.strb, 8'hF0);
    chk("B_ready_in_aw_cycle", req_ready_o, 1);
    chk("B_ready_pulses", pulses, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0; axi_rsp = '0;
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b00;
    #1;
    chk("B_b_ready", axi_req.b_ready, 1);
    chk("B_no_reissue", axi_req.aw_valid, 0);
    @(negedge clk_i);
    axi_rsp.b_valid = 1'b0;
    #1;
    chk("B_rsp_valid", rsp_valid_o, 1);
    chk("B_rsp_error", rsp_error_o, 0);
    chk("B_rsp_rdata", rsp_rdata_o, 0);

    // C: fill four outstanding loads, fifth blocked until a pop has landed
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      drive_req(0, 32'h4000 + 32'(4 * i), 0, 0, 2); axi_rsp.ar_ready = 1'b1;
      #1 chk($sformatf("C_issue%0d_ready", i), req_ready_o, 1);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      drive_req(0, 32'h4010, 0, 0, 2);
      #1;
      chk($sformatf("C_full_ready_c%0d", c), req_ready_o, 0);
      chk($sformatf("C_full_ar_valid_c%0d", c), axi_req.ar_valid, 0);
    end
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = {32'hB000_0000, 32'hA000_0000};
    #1;
    chk("C_r_ready_first", axi_req.r_ready, 1);
    chk("C_full_during_pop", req_ready_o, 0);
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("C_rsp0_valid", rsp_valid_o, 1);
    chk("C_rsp0_rdata", rsp_rdata_o, exp_c[0]);
    chk("C_fifth_ready", req_ready_o, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; axi_rsp.ar_ready = 1'b0;
      axi_rsp.r_valid = 1'b1;
      axi_rsp.r.data = {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
      #1;
      chk($sformatf("C_r_ready%0d", k), axi_req.r_ready, 1);
      if (k > 1) begin
        chk($sformatf("C_rsp%0d_valid", k - 1), rsp_valid_o, 1);
        chk($sformatf("C_rsp%0d_rdata", k - 1), rsp_rdata_o, exp_c[k-1]);
      end
    end
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b1; axi_rsp.b_valid = 1'b1; axi_rsp.r.data = 64'hDEAD;
    #1;
    chk("C_rsp4_rdata", rsp_rdata_o, exp_c[4]);
    chk("C_empty_r_ready", axi_req.r_ready, 0);
    chk("C_empty_b_ready", axi_req.b_ready, 0);

    // D: load then store, B arrives before R
    @(negedge clk_i);
    axi_rsp = '0;
    drive_req(0, 32'h5000, 0, 0, 2); axi_rsp.ar_ready = 1'b1;
    #1 chk("D_load_ready", req_ready_o, 1);
    @(negedge clk_i);
    axi_rsp.ar_ready = 1'b0;
    drive_req(1, 32'h5004, 32'hCAFE_F00D, 4'hF, 2);
    axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    #1 chk("D_store_ready", req_ready_o, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
      axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b00;
      #1 chk($sformatf("D_b_stalled_c%0d", c), axi_req.b_ready, 0);
    end
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h1111_2222_3333_4444; axi_rsp.r.resp = 2'b00;
    #1;
    chk("D_r_ready", axi_req.r_ready, 1);
    chk("D_b_still_stalled", axi_req.b_ready, 0);
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("D_load_rdata", rsp_rdata_o, 32'h3333_4444);
    chk("D_load_valid", rsp_valid_o, 1);
    chk("D_b_ready", axi_req.b_ready, 1);
    @(negedge clk_i);
    axi_rsp.b_valid = 1'b0;
    #1;
    chk("D_store_valid", rsp_valid_o, 1);
    chk("D_store_rdata", rsp_rdata_o, 0);

    // E: response backpressure, then error responses
    @(negedge clk_i);
    drive_req(0, 32'h6000, 0, 0, 2); axi_rsp.ar_ready = 1'b1;
    #1 chk("E_ld0_ready", req_ready_o, 1);
    @(negedge clk_i);
    drive_req(0, 32'h6004, 0, 0, 2);
    #1 chk("E_ld1_ready", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0; axi_rsp.ar_ready = 1'b0; rsp_ready_i = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h5555_6666_7777_8888; axi_rsp.r.resp = 2'b00;
    #1 chk("E_r_ready_first", axi_req.r_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      axi_rsp.r.data = 64'h9999_AAAA_BBBB_CCCC; axi_rsp.r.resp = 2'b10;
      #1;
      chk($sformatf("E_r_stall_c%0d", c), axi_req.r_ready, 0);
      chk($sformatf("E_hold_valid_c%0d", c), rsp_valid_o, 1);
      chk($sformatf("E_hold_rdata_c%0d", c), rsp_rdata_o, 32'h7777_8888);
    end
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    #1;
    chk("E_r_ready_release", axi_req.r_ready, 1);
    chk("E_first_error", rsp_error_o, 0);
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b0;
    #1;
    chk("E_second_rdata", rsp_rdata_o, 32'h9999_AAAA);
    chk("E_second_error", rsp_error_o, 1);
    @(negedge clk_i);
    drive_req(1, 32'h7000, 32'h0, 4'hF, 2);
    axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    #1 chk("E_store_ready", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0; axi_rsp = '0;
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b10;
    #1 chk("E_b_ready", axi_req.b_ready, 1);
    @(negedge clk_i);
    axi_rsp.b_valid = 1'b0;
    #1;
    chk("E_slverr_valid", rsp_valid_o, 1);
    chk("E_slverr_error", rsp_error_o, 1);

    // F: asynchronous reset with three loads outstanding
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive_req(0, 32'h8000 + 32'(4 * i), 0, 0, 2); axi_rsp.ar_ready = 1'b1;
      #1 chk($sformatf("F_issue%0d_ready", i), req_ready_o, 1);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h0123_4567_89AB_CDEF; axi_rsp.r.resp = 2'b00;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    #1;
    chk("F_pre_rsp_valid", rsp_valid_o, 1);
    chk("F_pre_rsp_rdata", rsp_rdata_o, 32'h89AB_CDEF);
    #1 rsp_ready_i = 1'b1;
    #1 chk("F_pre_r_ready", axi_req.r_ready, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("F_rst_rsp_valid", rsp_valid_o, 0);
    chk("F_rst_rsp_rdata", rsp_rdata_o, 0);
    chk("F_rst_r_ready", axi_req.r_ready, 0);
    chk("F_rst_req_ready", req_ready_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; axi_rsp.b_valid = 1'b1;
    #1;
    chk("F_empty_r_ready", axi_req.r_ready, 0);
    chk("F_empty_b_ready", axi_req.b_ready, 0);
    @(negedge clk_i);
    axi_rsp = '0;
    drive_req(0, 32'h9004, 0, 0, 2); axi_rsp.ar_ready = 1'b1;
    #1 chk("F_post_ready", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0; axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'hFEED_FACE_0000_0001;
    #1 chk("F_post_r_ready", axi_req.r_ready, 1);
    @(negedge clk_i);
    axi_rsp.r_valid = 1'b0;
    #1 chk("F_post_rdata", rsp_rdata_o, 32'hFEED_FACE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
